// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator in front of the combinational data
// memory DM. Each request is taken over a valid/ready handshake and checked
// for natural alignment. The block then issues dword-granular accesses to DM.
// Loads pick out the addressed lane and sign- or zero-extend it. Sub-dword
// stores are done as read-modify-write, because DM only writes whole dwords.
module lsu_mem_master (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [63:0] resp_rdata,
    output logic [63:0] mem_Address,
    output logic [63:0] mem_WriteData,
    output logic        mem_MemWrite,
    output logic        mem_MemRead,
    input  logic [63:0] mem_ReadData
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic        r_write;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [2:0]  r_off;
    logic [63:0] r_wdata;

    logic [63:0] r_memAddr;
    logic [63:0] r_memWdata;
    logic        r_respErr;
    logic [63:0] r_respRdata;

    logic        w_accept;
    logic        w_misaligned;
    logic        w_dwordStore;
    logic [5:0]  w_shiftAmt;
    logic [63:0] w_laneMask;
    logic [63:0] w_mergeMask;
    logic [63:0] w_merged;
    logic [63:0] w_lane;
    logic [63:0] w_extracted;

    assign w_accept     = req_valid && (r_state == S_IDLE);
    assign w_dwordStore = req_write && (req_size == 2'b11);

    // Natural alignment: the byte offset must be a multiple of the access size
    always_comb begin
        w_misaligned = 1'b0;
        case (req_size)
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = req_addr[0];
            2'b10:   w_misaligned = |req_addr[1:0];
            default: w_misaligned = |req_addr[2:0];
        endcase
    end

    // State register; a low rst_n abandons any access in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: misaligned requests skip memory; dword stores skip the read
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_misaligned) begin
                        w_nextState = S_RESP;
                    end else if (w_dwordStore) begin
                        w_nextState = S_WRITE;
                    end else begin
                        w_nextState = S_READ;
                    end
                end
            end
            S_READ:  w_nextState = r_write ? S_WRITE : S_RESP;
            S_WRITE: w_nextState = S_RESP;
            S_RESP:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Byte-lane helpers: merge store data into the fetched dword, or pull a load lane out of it
    always_comb begin
        w_shiftAmt = {r_off, 3'b000};
        w_laneMask = 64'hFFFF_FFFF_FFFF_FFFF;
        case (r_size)
            2'b00:   w_laneMask = 64'h0000_0000_0000_00FF;
            2'b01:   w_laneMask = 64'h0000_0000_0000_FFFF;
            2'b10:   w_laneMask = 64'h0000_0000_FFFF_FFFF;
            default: w_laneMask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        w_mergeMask = w_laneMask << w_shiftAmt;
        w_merged    = (mem_ReadData & ~w_mergeMask) | ((r_wdata << w_shiftAmt) & w_mergeMask);
        w_lane      = mem_ReadData >> w_shiftAmt;
        w_extracted = w_lane;
        case (r_size)
            2'b00:   w_extracted = r_unsigned ? {56'd0, w_lane[7:0]}
                                              : {{56{w_lane[7]}}, w_lane[7:0]};
            2'b01:   w_extracted = r_unsigned ? {48'd0, w_lane[15:0]}
                                              : {{48{w_lane[15]}}, w_lane[15:0]};
            2'b10:   w_extracted = r_unsigned ? {32'd0, w_lane[31:0]}
                                              : {{32{w_lane[31]}}, w_lane[31:0]};
            default: w_extracted = w_lane;
        endcase
    end

    // Request latch, memory address/data registers and response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_write     <= 1'b0;
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_off       <= 3'd0;
            r_wdata     <= 64'd0;
            r_memAddr   <= 64'd0;
            r_memWdata  <= 64'd0;
            r_respErr   <= 1'b0;
            r_respRdata <= 64'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_write     <= req_write;
                        r_size      <= req_size;
                        r_unsigned  <= req_unsigned;
                        r_off       <= req_addr[2:0];
                        r_wdata     <= req_wdata;
                        r_respErr   <= w_misaligned;
                        r_respRdata <= 64'd0;
                        if (!w_misaligned) begin
                            r_memAddr <= {req_addr[63:3], 3'b000};
                        end
                        if (!w_misaligned && w_dwordStore) begin
                            r_memWdata <= req_wdata;
                        end
                    end
                end
                S_READ: begin
                    if (r_write) begin
                        r_memWdata <= w_merged;
                    end else begin
                        r_respRdata <= w_extracted;
                    end
                end
                S_WRITE: begin
                    r_respRdata <= 64'd0;
                end
                S_RESP: begin
                    r_respErr   <= 1'b0;
                    r_respRdata <= 64'd0;
                end
                default: begin
                    r_respErr <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready     = (r_state == S_IDLE);
    assign mem_MemRead   = (r_state == S_READ);
    assign mem_MemWrite  = (r_state == S_WRITE);
    assign mem_Address   = r_memAddr;
    assign mem_WriteData = r_memWdata;
    assign resp_valid    = (r_state == S_RESP);
    assign resp_err      = r_respErr;
    assign resp_rdata    = r_respRdata;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Testbench for lsu_mem_master: a combinational DM model plus a byte-level
// reference memory that predicts load results, store merges and latencies.
module tb_lsu_mem_master;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [63:0] resp_rdata;
   logic [63:0] mem_Address;
   logic [63:0] mem_WriteData;
   logic        mem_MemWrite;
   logic        mem_MemRead;
   logic [63:0] mem_ReadData;

   logic [63:0] dmMem  [0:15];
   logic [63:0] refMem [0:15];
   logic        initMem;

   int testsRun;
   int testsFailed;

   lsu_mem_master dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_err     (resp_err),
      .resp_rdata   (resp_rdata),
      .mem_Address  (mem_Address),
      .mem_WriteData(mem_WriteData),
      .mem_MemWrite (mem_MemWrite),
      .mem_MemRead  (mem_MemRead),
      .mem_ReadData (mem_ReadData)
   );

   // Free-running clock, 10 time units per period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational DM: reads follow the address, writes land at the end of the strobe cycle
   assign mem_ReadData = dmMem[mem_Address[6:3]];
   always @(posedge clk) begin
      if (initMem) begin
         for (int k = 0; k < 16; k++) dmMem[k] <= refMem[k];
      end else if (mem_MemWrite) begin
         dmMem[mem_Address[6:3]] <= mem_WriteData;
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "_ready"},  {63'd0, req_ready}, 64'd1);
      checkOutput({tag, "_rvalid"}, {63'd0, resp_valid}, 64'd0);
      checkOutput({tag, "_rerr"},   {63'd0, resp_err}, 64'd0);
      checkOutput({tag, "_rdata"},  resp_rdata, 64'd0);
      checkOutput({tag, "_mrd"},    {63'd0, mem_MemRead}, 64'd0);
      checkOutput({tag, "_mwr"},    {63'd0, mem_MemWrite}, 64'd0);
      checkOutput({tag, "_maddr"},  mem_Address, 64'd0);
      checkOutput({tag, "_mwdata"}, mem_WriteData, 64'd0);
   endtask

   // One complete request: drive, watch every cycle until the response, compare with the model
   task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic uns,
                                input logic [63:0] addr, input logic [63:0] wdata,
                                output logic [63:0] rd, output logic [63:0] wd);
      int n, off, lat, expRd, expWr, rdC, wrC, respC, rdCount, wrCount, waitC;
      logic mis;
      logic [63:0] oldD, newD, expData, base;
      n    = 1 << sz;
      off  = int'(addr[2:0]);
      mis  = (off % n) != 0;
      base = {addr[63:3], 3'b000};
      rd   = 64'd0;
      wd   = 64'd0;

      waitC = 0;
      while (!req_ready && waitC < 20) begin
         @(posedge clk); #1;
         waitC++;
      end
      checkOutput("ready_before", {63'd0, req_ready}, 64'd1);

      @(negedge clk);
      req_valid    = 1'b1;
      req_write    = wr;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      @(posedge clk); #1;
      req_valid    = 1'b0;

      oldD = refMem[addr[6:3]];
      newD = oldD;
      expData = 64'd0;
      for (int k = 0; k < n; k++) begin
         newD[8*(off+k) +: 8] = wdata[8*k +: 8];
         expData[8*k +: 8]    = oldD[8*(off+k) +: 8];
      end
      if (!uns && n < 8 && expData[8*n-1]) begin
         for (int k = n; k < 8; k++) expData[8*k +: 8] = 8'hFF;
      end

      if (mis) begin
         lat = 1; expRd = 0; expWr = 0;
      end else if (wr && n == 8) begin
         lat = 2; expRd = 0; expWr = 1;
      end else if (wr) begin
         lat = 3; expRd = 1; expWr = 2;
      end else begin
         lat = 2; expRd = 1; expWr = 0;
      end

      rdC = 0; wrC = 0; respC = 0; rdCount = 0; wrCount = 0;
      for (int c = 1; c <= 8; c++) begin
         checkOutput("overlap", {63'd0, mem_MemRead & mem_MemWrite}, 64'd0);
         if (mem_MemRead) begin
            rdCount++;
            rdC = c;
            checkOutput("rd_addr", mem_Address, base);
         end
         if (mem_MemWrite) begin
            wrCount++;
            wrC = c;
            wd  = mem_WriteData;
            checkOutput("wr_addr", mem_Address, base);
         end
         if (resp_valid) begin
            respC = c;
            rd    = resp_rdata;
            checkOutput("resp_err", {63'd0, resp_err}, {63'd0, mis});
            checkOutput("resp_rdata", resp_rdata, (mis || wr) ? 64'd0 : expData);
            break;
         end
         @(posedge clk); #1;
      end

      checkOutput("latency", 64'(respC), 64'(lat));
      checkOutput("rd_cycle", 64'(rdC), 64'(expRd));
      checkOutput("wr_cycle", 64'(wrC), 64'(expWr));
      checkOutput("rd_count", 64'(rdCount), (expRd != 0) ? 64'd1 : 64'd0);
      checkOutput("wr_count", 64'(wrCount), (expWr != 0) ? 64'd1 : 64'd0);
      if (expWr != 0) checkOutput("wr_data", wd, newD);
      if (wr && !mis) refMem[addr[6:3]] = newD;

      @(posedge clk); #1;
      checkOutput("resp_pulse", {63'd0, resp_valid}, 64'd0);
      checkOutput("ready_after", {63'd0, req_ready}, 64'd1);
   endtask

   logic [63:0] rdv, wdv;
   int          accepts[$];
   int          rdPulses;

   // Main sequence: reset, directed cases, handshake, reset abort, random traffic, memory audit
   initial begin
      testsRun     = 0;
      testsFailed  = 0;
      rst_n        = 1'b0;
      initMem      = 1'b1;
      req_valid    = 1'b0;
      req_write    = 1'b0;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_addr     = 64'd0;
      req_wdata    = 64'd0;
      for (int k = 0; k < 16; k++) refMem[k] = {$urandom, $urandom};
      repeat (2) @(posedge clk);
      #1;
      rst_n   = 1'b1;
      initMem = 1'b0;
      checkIdleOutputs("reset");

      applyStimulus(1'b1, 2'b11, 1'b0, 64'h40, 64'h1122334455667788, rdv, wdv);
      checkOutput("tp_store_wd", wdv, 64'h1122334455667788);
      applyStimulus(1'b0, 2'b11, 1'b0, 64'h40, 64'd0, rdv, wdv);
      checkOutput("tp_load_dw", rdv, 64'h1122334455667788);
      applyStimulus(1'b0, 2'b00, 1'b0, 64'h47, 64'd0, rdv, wdv);
      checkOutput("tp_byte47", rdv, 64'h11);
      applyStimulus(1'b0, 2'b00, 1'b0, 64'h40, 64'd0, rdv, wdv);
      checkOutput("tp_byte40s", rdv, 64'hFFFFFFFFFFFFFF88);
      applyStimulus(1'b0, 2'b00, 1'b1, 64'h40, 64'd0, rdv, wdv);
      checkOutput("tp_byte40u", rdv, 64'h88);
      applyStimulus(1'b1, 2'b01, 1'b0, 64'h42, 64'hBEEF, rdv, wdv);
      checkOutput("tp_half_rmw", wdv, 64'h11223344BEEF7788);
      applyStimulus(1'b0, 2'b10, 1'b0, 64'h40, 64'd0, rdv, wdv);
      checkOutput("tp_word40", rdv, 64'hFFFFFFFFBEEF7788);
      applyStimulus(1'b0, 2'b10, 1'b0, 64'h46, 64'd0, rdv, wdv);
      applyStimulus(1'b1, 2'b01, 1'b0, 64'h41, 64'hDEAD, rdv, wdv);
      checkOutput("tp_mis_mem", dmMem[8], 64'h11223344BEEF7788);

      // Two dword loads with req_valid held high the whole time
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_size  = 2'b11;
      req_addr  = 64'h40;
      rdPulses  = 0;
      for (int i = 0; i < 12; i++) begin
         if (req_valid && req_ready) accepts.push_back(i);
         if (mem_MemRead) rdPulses++;
         checkOutput("hs_overlap", {63'd0, mem_MemRead & mem_MemWrite}, 64'd0);
         @(posedge clk); #1;
         if (accepts.size() == 2) req_valid = 1'b0;
      end
      checkOutput("hs_accepts", 64'(accepts.size()), 64'd2);
      if (accepts.size() == 2) checkOutput("hs_gap", 64'(accepts[1] - accepts[0]), 64'd3);
      checkOutput("hs_reads", 64'(rdPulses), 64'd2);

      // Reset during the READ of a byte store must abort with no write and no response
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_size  = 2'b00;
      req_addr  = 64'h49;
      req_wdata = 64'hA5;
      @(posedge clk); #1;
      req_valid = 1'b0;
      checkOutput("rst_in_read", {63'd0, mem_MemRead}, 64'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      checkIdleOutputs("rst_abort");
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         checkOutput("rst_no_wr", {63'd0, mem_MemWrite}, 64'd0);
         checkOutput("rst_no_resp", {63'd0, resp_valid}, 64'd0);
      end

      // Randomized traffic over eight dwords at 0x40..0x7F
      for (int t = 0; t < 150; t++) begin
         logic [1:0]  sz;
         logic [63:0] a;
         int          o;
         sz = 2'($urandom_range(0, 3));
         o  = int'($urandom_range(0, 7));
         if ($urandom_range(0, 3) != 0) o = o & ~((1 << sz) - 1);
         a  = 64'h40 + 64'(8 * $urandom_range(0, 7)) + 64'(o);
         applyStimulus(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                       {$urandom, $urandom}, rdv, wdv);
      end

      for (int k = 8; k < 16; k++) checkOutput("mem_final", dmMem[k], refMem[k]);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store initiator that sits between the datapath and the combinational data memory `DM`. It accepts one load or store request at a time over a valid/ready handshake and checks natural alignment. It then drives the memory's `Address`/`WriteData`/`MemWrite`/`MemRead`/`ReadData` interface with dword-granular accesses. Sub-dword loads are lane-extracted and sign- or zero-extended; sub-dword stores are done as read-modify-write, because `DM` only supports whole-dword writes on 8-byte boundaries.

## Interface
- `dword`, 64: data and address width (bits).
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept; equals (state == IDLE).
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 dword.
- `req_unsigned`  in  1  loads only: 1 zero-extend, 0 sign-extend.
- `req_addr`  in  dword  byte address.
- `req_wdata`  in  dword  store data, right-aligned (low bits used).
- `resp_valid`  out  1  one-cycle completion pulse; no backpressure.
- `resp_err`  out  1  valid with `resp_valid`; 1 = misaligned, no memory access made.
- `resp_rdata`  out  dword  load result; 0 for stores and errors.
- `mem_Address`  out  dword  to DM `Address`; always a multiple of 8.
- `mem_WriteData`  out  dword  to DM `WriteData`.
- `mem_MemWrite`  out  1  to DM `MemWrite`.
- `mem_MemRead`  out  1  to DM `MemRead`.
- `mem_ReadData`  in  dword  from DM `ReadData`.

## Operation
- Request fields are latched on acceptance (`req_valid & req_ready` at the rising edge).
- Address fields: base = addr with bits [2:0] cleared; off = addr[2:0]; nbytes = 1 << req_size.
- Misaligned when off mod nbytes != 0. The request goes straight to RESP with `resp_err`=1 and no strobes.
- Little-endian lanes: byte k of the dword is bits [8k+7:8k].
- States: IDLE, READ, WRITE, RESP.
- IDLE: on accept, go to RESP if misaligned; WRITE if store and dword; otherwise READ.
- READ: `mem_MemRead`=1, `mem_Address`=base. `mem_ReadData` is captured into an internal dword register at the end of the cycle. Next state is WRITE for a store, RESP for a load.
- WRITE: `mem_MemWrite`=1, `mem_Address`=base. `mem_WriteData` is either `req_wdata` (dword) or the captured dword with bytes [off, off+nbytes) replaced by the low nbytes of `req_wdata`. Next state is RESP.
- RESP: `resp_valid`=1. For a load, `resp_rdata` holds the extracted lane, extended to 64 bits per `req_unsigned` (dword ignores it). Next state is IDLE.
- `mem_MemRead` and `mem_MemWrite` are never high in the same cycle. Each is high for exactly one cycle per access.
- Outside READ/WRITE, `mem_Address` and `mem_WriteData` hold their last values, and both strobes are 0.

## Timing
- Reset (`rst_n`=0 at an edge) puts the block in IDLE and clears both strobes, `resp_valid`, `resp_err`, `resp_rdata`, `mem_Address` and `mem_WriteData`. `req_ready`=1 from the first cycle in IDLE. Requests are never accepted while `rst_n`=0.
- Memory outputs and `resp_*` are registered: driven from state and latched registers, with no combinational path from `req_*`.
- Cycle 0 is the acceptance edge. Latency to `resp_valid`:
  - dword store: 2 cycles (WRITE in cycle 1, RESP in cycle 2);
  - load: 2 cycles (READ, RESP);
  - sub-dword store: 3 cycles (READ, WRITE, RESP);
  - misaligned: 1 cycle.
- `req_ready` is 0 from cycle 1 until the cycle after RESP. Back-to-back throughput is one request per (latency + 1) cycles.
- `mem_Address` and `mem_WriteData` are stable for the whole strobe cycle. `DM` is combinational, so a write takes effect within its WRITE cycle.
- Reset mid-operation aborts to IDLE with no response.
  - A WRITE cycle in which `rst_n` is sampled low has already written memory.
  - A READ aborted by reset performs no write.
- `req_valid` held high in RESP is not accepted until the following IDLE cycle.

## Test plan
- Dword store then load: store 0x1122334455667788 at 0x40, then load dword from 0x40.
  - Store: `mem_MemWrite` pulses at cycle 1, `resp_valid` at cycle 2, `resp_err`=0.
  - Load: `resp_rdata`=0x1122334455667788.
- Signed byte load: memory[0x40]=0x1122334455667788; load byte at 0x47 with `req_unsigned`=0 gives 0x0000000000000011. Load byte at 0x40 gives 0x...0088 sign-extended to 0xFFFFFFFFFFFFFF88; with `req_unsigned`=1 it gives 0x88.
- Half store read-modify-write: store half 0xBEEF at 0x42 over 0x1122334455667788.
  - READ at cycle 1, WRITE at cycle 2 with `mem_WriteData`=0x11223344BEEF7788, `mem_Address`=0x40, `resp_valid` at cycle 3.
  - Word load from 0x40 returns 0xFFFFFFFFBEEF7788.
- Misaligned: word load at 0x46 and half store at 0x41. Each gives `resp_valid`=1 and `resp_err`=1 at cycle 1, with no strobe ever high; memory is unchanged.
- Handshake: `req_valid` held high continuously with two queued dword loads. Second acceptance occurs exactly 3 cycles after the first, and strobes never overlap.
- Reset mid-op: `rst_n`=0 during READ of a sub-dword store. No `mem_MemWrite` pulse and no `resp_valid`; all outputs are 0 and `req_ready`=1 the cycle after reset releases.
